// File: rtl/pri_enc_pkg.sv
// Shared constants and the MSB-first index helper for the pri_enc8 priority encoder.
package pri_enc_pkg;

    localparam int unsigned PRI_ENC_WIDTH = 8;
    localparam int unsigned PRI_ENC_IDX_W = 3;

    // Later (higher) set bits overwrite earlier ones, so the MSB wins.
    function automatic logic [PRI_ENC_IDX_W-1:0] msb_index(input logic [PRI_ENC_WIDTH-1:0] v);
        logic [PRI_ENC_IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < PRI_ENC_WIDTH; i++) begin
            if (v[i]) begin
                idx = i[PRI_ENC_IDX_W-1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pri_enc_core.sv
// Combinational core: index of the highest set bit of d plus an "any bit set" flag.
module pri_enc_core
    import pri_enc_pkg::*;
#(
    parameter int unsigned WIDTH = PRI_ENC_WIDTH
) (
    input  logic [WIDTH-1:0]         d,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     any
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

    assign any = |d;

    generate
        if (WIDTH == PRI_ENC_WIDTH) begin : g_pkg
            assign idx = msb_index(d);
        end else begin : g_loop
            always_comb begin
                idx = '0;
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (d[i]) begin
                        idx = i[IDX_W-1:0];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/pri_enc8.sv
// Registered priority encoder with enable; define PRI_ENC8_ONEHOT_EN to add the one-hot grant output.
module pri_enc8
    import pri_enc_pkg::*;
#(
    parameter int unsigned WIDTH = PRI_ENC_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         d,
    input  logic                     en,
    output logic [$clog2(WIDTH)-1:0] y,
    output logic                     valid
`ifdef PRI_ENC8_ONEHOT_EN
    ,
    output logic [WIDTH-1:0]         grant
`endif
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

    logic [IDX_W-1:0] idx;
    logic             any;
    logic             hit;
    logic [IDX_W-1:0] y_nxt;

    pri_enc_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .d   (d),
        .idx (idx),
        .any (any)
    );

    // Ternaries rather than if/else so an X on d or en propagates instead of picking a branch.
    assign hit   = en & any;
    assign y_nxt = hit ? idx : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y     <= '0;
            valid <= 1'b0;
        end else begin
            y     <= y_nxt;
            valid <= hit;
        end
    end

`ifdef PRI_ENC8_ONEHOT_EN
    logic [WIDTH-1:0] grant_nxt;

    assign grant_nxt = hit ? (WIDTH'(1) << y_nxt) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant <= '0;
        end else begin
            grant <= grant_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_pri_enc8.sv
// Directed self-checking bench for pri_enc8; grant checks are included when PRI_ENC8_ONEHOT_EN is defined.
module tb_pri_enc8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] d = 8'h00;
    logic       en = 1'b0;
    logic [2:0] y;
    logic       valid;
`ifdef PRI_ENC8_ONEHOT_EN
    logic [7:0] grant;
`endif

    int checks = 0;
    int errors = 0;

    pri_enc8 #(
        .WIDTH (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d),
        .en    (en),
        .y     (y),
        .valid (valid)
`ifdef PRI_ENC8_ONEHOT_EN
        ,
        .grant (grant)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive inputs, then return at the next negedge (one posedge later).
    task automatic cyc(input logic [7:0] dv, input logic ev);
        d  = dv;
        en = ev;
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic [2:0] ey, input logic ev);
        check({tag, "_y"}, {29'd0, y}, {29'd0, ey});
        check({tag, "_valid"}, {31'd0, valid}, {31'd0, ev});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset asserted with no clock edge yet
        d     = 8'hFF;
        en    = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_out("reset_async", 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_out("reset_release", 3'd7, 1'b1);

        // Single and stacked bits
        cyc(8'h01, 1'b1); check_out("d01", 3'd0, 1'b1);
        cyc(8'h03, 1'b1); check_out("d03", 3'd1, 1'b1);
        cyc(8'h05, 1'b1); check_out("d05", 3'd2, 1'b1);
        cyc(8'h09, 1'b1); check_out("d09", 3'd3, 1'b1);
        cyc(8'h11, 1'b1); check_out("d11", 3'd4, 1'b1);
        cyc(8'h31, 1'b1); check_out("d31", 3'd5, 1'b1);
        cyc(8'h71, 1'b1); check_out("d71", 3'd6, 1'b1);

        // Mixed patterns
        cyc(8'hC9, 1'b1); check_out("dC9", 3'd7, 1'b1);
        cyc(8'hB9, 1'b1); check_out("dB9", 3'd7, 1'b1);
        cyc(8'h2A, 1'b1); check_out("d2A", 3'd5, 1'b1);
`ifdef PRI_ENC8_ONEHOT_EN
        check("grant_2A", {24'd0, grant}, 32'h20);
`endif
        cyc(8'hA2, 1'b1); check_out("dA2", 3'd7, 1'b1);
        cyc(8'h00, 1'b1); check_out("d00", 3'd0, 1'b0);
`ifdef PRI_ENC8_ONEHOT_EN
        check("grant_00", {24'd0, grant}, 32'h00);
`endif

        // Enable gating with d held
        cyc(8'h40, 1'b1); check_out("en1_a", 3'd6, 1'b1);
`ifdef PRI_ENC8_ONEHOT_EN
        check("grant_40", {24'd0, grant}, 32'h40);
`endif
        cyc(8'h40, 1'b0); check_out("en0", 3'd0, 1'b0);
`ifdef PRI_ENC8_ONEHOT_EN
        check("grant_en0", {24'd0, grant}, 32'h00);
`endif
        cyc(8'h40, 1'b1); check_out("en1_b", 3'd6, 1'b1);
        cyc(8'hFF, 1'b0); check_out("en0_ff", 3'd0, 1'b0);

        // Holding inputs steady holds outputs
        cyc(8'h09, 1'b1); check_out("hold_a", 3'd3, 1'b1);
        cyc(8'h09, 1'b1); check_out("hold_b", 3'd3, 1'b1);

        // Reset pulse between edges while streaming
        cyc(8'h80, 1'b1); check_out("stream", 3'd7, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_out("reset_mid", 3'd0, 1'b0);
`ifdef PRI_ENC8_ONEHOT_EN
        check("grant_reset", {24'd0, grant}, 32'h00);
`endif
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_out("after_reset", 3'd7, 1'b1);
`ifdef PRI_ENC8_ONEHOT_EN
        check("grant_80", {24'd0, grant}, 32'h80);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pri_enc8.md
Name: pri_enc8

Overview:
- Registered 8-to-3 priority encoder with enable.
- Reports the index of the highest-numbered asserted input bit, plus a valid flag.
- Used wherever a request vector must be reduced to a single winning index, e.g. interrupt or arbitration front-ends.
- Outputs are registered, so downstream logic sees a clean, glitch-free index one cycle after the inputs are sampled.

Parameters:
- WIDTH, 8, number of request inputs; must be a power of two, >= 2.
- IDX_W, $clog2(WIDTH) (3 at default), width of the encoded index output; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- d  input  WIDTH  request vector; bit i asserted means request i is active.
- en  input  1  encoder enable; sampled each cycle.
- y  output  IDX_W  registered index of the highest set bit of d.
- valid  output  1  registered flag: y holds a genuine encoding.

Behaviour:
- Reset:
  - Asserting rst_n low immediately forces y=0 and valid=0, independent of clk.
  - Deassertion takes effect at the next rising clk edge.
- Priority: MSB wins. y = largest i such that d[i]=1.
  - Example: d=8'b0011_0001 gives y=3'd5.
- Latency: one cycle. Values of d and en sampled at rising edge N appear on y/valid after edge N. There is no combinational path from inputs to outputs.
- At each rising edge (not in reset):
  - If en=1 and d!=0: y <= index of the highest set bit; valid <= 1.
  - If en=1 and d==0: y <= 0; valid <= 0.
  - If en=0: y <= 0; valid <= 0, regardless of d.
- d=8'b0000_0001 gives y=0, valid=1. This is distinguished from the no-request case only by valid.
- Holding inputs steady holds the outputs steady. The block has no internal state beyond the output registers and no FSM.
- Reset asserted mid-operation clears the outputs at once. The first post-reset edge re-samples the inputs normally.
- X on d or en must not be resolved optimistically. Simulation may propagate X.

Optional Feature:
- Macro PRI_ENC8_ONEHOT_EN.
- When defined:
  - Adds output port "grant" (output, WIDTH), a registered one-hot vector with only bit y set when valid=1, else all zero.
  - grant resets to 0 asynchronously with y and valid.
  - grant updates on the same edge as y and valid, with the same one-cycle latency.
- When undefined: the port and its register do not exist; all other behaviour is identical.

Decomposition:
- Shared package pri_enc_pkg holds:
  - localparam PRI_ENC_WIDTH = 8 and PRI_ENC_IDX_W = 3.
  - A function that returns the MSB-first index of a WIDTH-bit vector.
- One sub-module, pri_enc_core: purely combinational. It takes d and returns the index plus an "any" flag.
- pri_enc8 instantiates pri_enc_core and adds en gating, the output registers, and the optional grant register.

Test Plan:
- Reset: drive rst_n=0 with d=8'hFF, en=1, and no clock edge -> y=0, valid=0 immediately. Release rst_n, then one edge -> y=7, valid=1.
- Single and stacked bits, en=1, one edge each:
  - 8'h01 -> y=0
  - 8'h03 -> y=1
  - 8'h05 -> y=2
  - 8'h09 -> y=3
  - 8'h11 -> y=4
  - 8'h31 -> y=5
  - 8'h71 -> y=6
  - valid=1 in every case.
- Mixed patterns, en=1:
  - 8'hC9 -> y=7
  - 8'hB9 -> y=7
  - 8'h2A -> y=5
  - 8'hA2 -> y=7
  - 8'h00 -> y=0, valid=0
- Enable gating: d=8'h40 held, toggle en 1,0,1 on consecutive edges -> y/valid sequence 6/1, 0/0, 6/1. Each output lags its en value by exactly one edge.
- Reset mid-run: d=8'h80, en=1 streaming; pulse rst_n low between edges -> outputs drop to 0/0 during the pulse. The next edge after release -> y=7, valid=1.
- With PRI_ENC8_ONEHOT_EN defined:
  - d=8'h2A -> grant=8'h20.
  - d=8'h00 -> grant=8'h00.
  - en=0 -> grant=8'h00.
